// File: rtl/can_rx_fifo_pkg.sv
// ============================================================================
// can_rx_fifo_pkg : shared widths and slot layout for the CAN receive FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

package can_rx_fifo_pkg;

  localparam int CAN_ID_W   = 29;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;
  localparam int FRAME_W    = 2 + CAN_DLC_W + CAN_ID_W + CAN_DATA_W;  // 99

  // Slot layout, MSB to LSB: {ext, rtr, dlc, id, data}
  localparam int DATA_LSB = 0;
  localparam int ID_LSB   = DATA_LSB + CAN_DATA_W;
  localparam int DLC_LSB  = ID_LSB + CAN_ID_W;
  localparam int RTR_BIT  = DLC_LSB + CAN_DLC_W;
  localparam int EXT_BIT  = RTR_BIT + 1;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic                  ext,
    input logic                  rtr,
    input logic [CAN_DLC_W-1:0]  dlc,
    input logic [CAN_ID_W-1:0]   id,
    input logic [CAN_DATA_W-1:0] data
  );
    return {ext, rtr, dlc, id, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/can_rx_fifo_mem.sv
// ============================================================================
// can_rx_fifo_mem : DEPTH x FRAME_W frame storage, sync write / async read
// Revision 1.0
// ============================================================================
`default_nettype none

module can_rx_fifo_mem
  import can_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [FRAME_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [FRAME_W-1:0] rdata_o
);

  logic [FRAME_W-1:0] mem_q [DEPTH];

  // Storage is deliberately not reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/can_rx_fifo.sv
// ============================================================================
// can_rx_fifo : receive-frame queue between CAN controller and CPU registers.
// Optional acceptance filter enabled by defining CAN_RX_FIFO_FILTER_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module can_rx_fifo
  import can_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [CAN_ID_W-1:0]   in_id,
  input  logic                  in_ext,
  input  logic                  in_rtr,
  input  logic [CAN_DLC_W-1:0]  in_dlc,
  input  logic [CAN_DATA_W-1:0] in_data,
  input  logic                  pop,
  input  logic                  ovf_clr,
  input  logic [LW-1:0]         irq_thresh,
  input  logic [CAN_ID_W-1:0]   acc_code,
  input  logic [CAN_ID_W-1:0]   acc_mask,
  output logic [CAN_ID_W-1:0]   head_id,
  output logic                  head_ext,
  output logic                  head_rtr,
  output logic [CAN_DLC_W-1:0]  head_dlc,
  output logic [CAN_DATA_W-1:0] head_data,
  output logic                  empty,
  output logic                  full,
  output logic [LW-1:0]         level,
  output logic                  ovf,
  output logic [7:0]            rej_cnt,
  output logic                  irq
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               irq_q, irq_d;
  logic               accepted;
  logic               push_en;
  logic               pop_en;
  logic               ovf_set;
  logic [FRAME_W-1:0] rd_frame;

`ifdef CAN_RX_FIFO_FILTER_EN
  logic [7:0] rej_cnt_q, rej_cnt_d;

  assign accepted = (((in_id ^ acc_code) & acc_mask) == '0);

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (in_valid && !accepted && (rej_cnt_q != 8'hFF)) begin
      rej_cnt_d = rej_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rej_cnt_q <= 8'd0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
    end
  end

  assign rej_cnt = rej_cnt_q;
`else
  logic unused_acc;

  assign unused_acc = ^{acc_code, acc_mask};
  assign accepted   = 1'b1;
  assign rej_cnt    = 8'd0;
`endif

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign ovf     = ovf_q;
  assign irq     = irq_q;

  // A pop on a full FIFO frees the slot the incoming frame needs this cycle.
  assign push_en = in_valid & accepted & (~full | pop);
  assign pop_en  = pop & ~empty;
  assign ovf_set = in_valid & accepted & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_en && !pop_en) begin
      level_d = level_q + LW'(1);
    end else if (pop_en && !push_en) begin
      level_d = level_q - LW'(1);
    end
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    irq_d = ((irq_thresh != '0) && (level_q >= irq_thresh)) || ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  can_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (pack_frame(in_ext, in_rtr, in_dlc, in_id, in_data)),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_frame)
  );

  // Slot contents are unreset, so the head view is masked while empty.
  assign head_id   = empty ? '0   : rd_frame[ID_LSB +: CAN_ID_W];
  assign head_dlc  = empty ? '0   : rd_frame[DLC_LSB +: CAN_DLC_W];
  assign head_data = empty ? '0   : rd_frame[DATA_LSB +: CAN_DATA_W];
  assign head_rtr  = empty ? 1'b0 : rd_frame[RTR_BIT];
  assign head_ext  = empty ? 1'b0 : rd_frame[EXT_BIT];

endmodule

`default_nettype wire

// File: tb/tb_can_rx_fifo.sv
// ============================================================================
// tb_can_rx_fifo : directed self-checking bench for can_rx_fifo (DEPTH=4)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_can_rx_fifo;

  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [28:0]   in_id = '0;
  logic          in_ext = 1'b0;
  logic          in_rtr = 1'b0;
  logic [3:0]    in_dlc = '0;
  logic [63:0]   in_data = '0;
  logic          pop = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [LW-1:0] irq_thresh = '0;
  logic [28:0]   acc_code = '0;
  logic [28:0]   acc_mask = '0;
  logic [28:0]   head_id;
  logic          head_ext;
  logic          head_rtr;
  logic [3:0]    head_dlc;
  logic [63:0]   head_data;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          ovf;
  logic [7:0]    rej_cnt;
  logic          irq;

  int n_checks = 0;
  int n_fail   = 0;

  can_rx_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_id      (in_id),
    .in_ext     (in_ext),
    .in_rtr     (in_rtr),
    .in_dlc     (in_dlc),
    .in_data    (in_data),
    .pop        (pop),
    .ovf_clr    (ovf_clr),
    .irq_thresh (irq_thresh),
    .acc_code   (acc_code),
    .acc_mask   (acc_mask),
    .head_id    (head_id),
    .head_ext   (head_ext),
    .head_rtr   (head_rtr),
    .head_dlc   (head_dlc),
    .head_data  (head_data),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .ovf        (ovf),
    .rej_cnt    (rej_cnt),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_frame(input logic [28:0] id, input logic [3:0] dlc,
                             input logic [63:0] data, input logic ext, input logic rtr);
    in_valid = 1'b1;
    in_id    = id;
    in_dlc   = dlc;
    in_data  = data;
    in_ext   = ext;
    in_rtr   = rtr;
  endtask

  task automatic push(input logic [28:0] id);
    drive_frame(id, 4'd8, {35'd0, id}, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full",  64'(full),  64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf",   64'(ovf),   64'd0);
    check("rst_irq",   64'(irq),   64'd0);
    check("rst_rej",   64'(rej_cnt), 64'd0);
    check("rst_head",  {head_ext, head_rtr, head_dlc, head_id[28:0]} | 64'(head_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single frame: visible the cycle after push, gone after pop
    drive_frame(29'h123, 4'd2, 64'hBEEF, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("one_id",    64'(head_id),   64'h123);
    check("one_data",  head_data,      64'hBEEF);
    check("one_dlc",   64'(head_dlc),  64'd2);
    check("one_rtr",   64'(head_rtr),  64'd1);
    check("one_level", 64'(level),     64'd1);
    check("one_empty", 64'(empty),     64'd0);
    pop_one();
    check("one_popped_empty", 64'(empty),   64'd1);
    check("one_popped_head",  64'(head_id), 64'd0);

    // Pop while empty is ignored
    pop_one();
    check("uflow_level", 64'(level), 64'd0);
    check("uflow_empty", 64'(empty), 64'd1);

    // Overflow: five pushes into four slots
    for (int i = 1; i <= 4; i++) push(29'(i));
    check("fill_full",  64'(full),  64'd1);
    check("fill_level", 64'(level), 64'd4);
    check("fill_ovf",   64'(ovf),   64'd0);
    push(29'd5);
    check("ovf_set",    64'(ovf),     64'd1);
    check("ovf_level",  64'(level),   64'd4);
    check("ovf_irq_lag", 64'(irq),    64'd0);
    tick();
    check("ovf_irq",    64'(irq),     64'd1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_id%0d", i), 64'(head_id), 64'(i));
      check($sformatf("drain_data%0d", i), head_data, 64'(i));
      pop_one();
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_ovf_sticky", 64'(ovf), 64'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 64'(ovf), 64'd0);
    tick();
    check("ovf_clr_irq", 64'(irq), 64'd0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) push(29'(32'h10 + i));
    drive_frame(29'h14, 4'd8, 64'h14, 1'b0, 1'b0);
    pop = 1'b1;
    tick();
    in_valid = 1'b0;
    pop = 1'b0;
    check("fullpp_level", 64'(level), 64'd4);
    check("fullpp_ovf",   64'(ovf),   64'd0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("fullpp_id%0d", i), 64'(head_id), 64'(32'h10 + i));
      pop_one();
    end
    check("fullpp_empty", 64'(empty), 64'd1);

    // Empty FIFO with simultaneous push and pop; dlc > 8 kept verbatim
    drive_frame(29'h1ABCDEF0, 4'hF, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
    pop = 1'b1;
    tick();
    in_valid = 1'b0;
    pop = 1'b0;
    check("emptypp_level", 64'(level),    64'd1);
    check("emptypp_id",    64'(head_id),  64'h1ABCDEF0);
    check("emptypp_ext",   64'(head_ext), 64'd1);
    check("emptypp_dlc",   64'(head_dlc), 64'hF);
    check("emptypp_data",  head_data,     64'h0123_4567_89AB_CDEF);
    pop_one();

    // Level interrupt
    irq_thresh = 3'd2;
    push(29'h21);
    push(29'h22);
    check("irq_lag",  64'(irq),   64'd0);
    check("irq_lvl2", 64'(level), 64'd2);
    tick();
    check("irq_set",  64'(irq),   64'd1);
    pop_one();
    tick();
    check("irq_clr",  64'(irq),   64'd0);
    push(29'h23);
    push(29'h24);
    push(29'h25);
    check("irq_full", 64'(full), 64'd1);
    drive_frame(29'h26, 4'd1, 64'h26, 1'b0, 1'b0);
    ovf_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", 64'(ovf), 64'd1);
    check("ovf_drop_head", 64'(head_id), 64'h22);
    for (int i = 0; i < 4; i++) pop_one();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    irq_thresh = '0;
    tick();

    // Acceptance filter
    acc_mask = 29'h7F0;
    acc_code = 29'h120;
    push(29'h125);
    push(29'h135);
`ifdef CAN_RX_FIFO_FILTER_EN
    check("flt_level", 64'(level),   64'd1);
    check("flt_rej",   64'(rej_cnt), 64'd1);
`else
    check("flt_level", 64'(level),   64'd2);
    check("flt_rej",   64'(rej_cnt), 64'd0);
`endif
    check("flt_head",  64'(head_id), 64'h125);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
